// File: rtl/hazard_scoreboard.sv
// Decode-side interlock for the 5-stage no-forwarding core: per-register pending-write
// counters, ID stall on RAW hazards, and IF/ID squash on a taken branch/jump in EX.
module hazard_scoreboard #(
    parameter int NUM_REGS  = 32,
    parameter int CNT_W     = 2,
    parameter int WB_BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_rs1_used_i,
    input  logic        id_rs2_used_i,
    input  logic [4:0]  id_rd_addr_i,
    input  logic        id_reg_write_i,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_rd_addr_i,
    input  logic        wb_reg_write_i,
    input  logic        ex_redirect_i,
    output logic        pc_stall_o,
    output logic        if_id_stall_o,
    output logic        if_id_flush_o,
    output logic        id_ex_bubble_o,
    output logic [31:0] stall_count_o,
    output logic        sb_error_o
);

    localparam logic             BYP_EN  = (WB_BYPASS != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_REGS-1:0][CNT_W-1:0] r_pending;
    logic [NUM_REGS-1:0][CNT_W-1:0] w_pending_next;
    logic [NUM_REGS-1:0]            w_err_vec;
    logic [31:0]                    r_stall_count;
    logic                           r_sb_error;

    logic [CNT_W-1:0] w_rs1_cnt;
    logic [CNT_W-1:0] w_rs2_cnt;
    logic             w_wb_wr;
    logic             w_rs1_byp;
    logic             w_rs2_byp;
    logic             w_src1_hz;
    logic             w_src2_hz;
    logic             w_hazard;
    logic             w_issue;
    logic             w_inc;
    logic             w_stall;

    assign w_rs1_cnt = r_pending[id_rs1_addr_i];
    assign w_rs2_cnt = r_pending[id_rs2_addr_i];

    assign w_wb_wr = wb_valid_i & wb_reg_write_i & (wb_rd_addr_i != 5'd0);

    // Only the last outstanding write can be retired by a same-cycle WB; older ones still block.
    assign w_rs1_byp = BYP_EN & w_wb_wr & (wb_rd_addr_i == id_rs1_addr_i) & (w_rs1_cnt == CNT_ONE);
    assign w_rs2_byp = BYP_EN & w_wb_wr & (wb_rd_addr_i == id_rs2_addr_i) & (w_rs2_cnt == CNT_ONE);

    assign w_src1_hz = id_rs1_used_i & (id_rs1_addr_i != 5'd0) & (w_rs1_cnt != '0) & ~w_rs1_byp;
    assign w_src2_hz = id_rs2_used_i & (id_rs2_addr_i != 5'd0) & (w_rs2_cnt != '0) & ~w_rs2_byp;

    assign w_hazard = id_valid_i & (w_src1_hz | w_src2_hz);
    assign w_issue  = id_valid_i & ~w_hazard & ~ex_redirect_i;
    assign w_inc    = w_issue & id_reg_write_i & (id_rd_addr_i != 5'd0);
    assign w_stall  = w_hazard & ~ex_redirect_i;

    assign pc_stall_o     = w_stall;
    assign if_id_stall_o  = w_stall;
    assign id_ex_bubble_o = w_hazard | ex_redirect_i;
    assign if_id_flush_o  = ex_redirect_i;
    assign stall_count_o  = r_stall_count;
    assign sb_error_o     = r_sb_error;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
            if (gi == 0) begin : g_x0
                assign w_pending_next[gi] = '0;
                assign w_err_vec[gi]      = 1'b0;
            end else begin : g_reg
                logic             w_inc_here;
                logic             w_dec_here;
                logic [CNT_W-1:0] w_next;
                logic             w_err;

                assign w_inc_here = w_inc   & (id_rd_addr_i == 5'(gi));
                assign w_dec_here = w_wb_wr & (wb_rd_addr_i == 5'(gi));

                always_comb begin
                    w_next = r_pending[gi];
                    w_err  = 1'b0;
                    if (w_inc_here && w_dec_here) begin
                        w_next = r_pending[gi];
                    end else if (w_inc_here) begin
                        if (r_pending[gi] == CNT_MAX) begin
                            w_err = 1'b1;
                        end else begin
                            w_next = r_pending[gi] + CNT_ONE;
                        end
                    end else if (w_dec_here) begin
                        if (r_pending[gi] == '0) begin
                            w_err = 1'b1;
                        end else begin
                            w_next = r_pending[gi] - CNT_ONE;
                        end
                    end
                end

                assign w_pending_next[gi] = w_next;
                assign w_err_vec[gi]      = w_err;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending     <= '0;
            r_stall_count <= '0;
            r_sb_error    <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if (|w_err_vec) begin
                r_sb_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: each cycle's expected stall/bubble/flush is queued
// with the stimulus and popped for comparison just after the inputs settle.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        id_valid_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic        id_rs1_used_i;
    logic        id_rs2_used_i;
    logic [4:0]  id_rd_addr_i;
    logic        id_reg_write_i;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_addr_i;
    logic        wb_reg_write_i;
    logic        ex_redirect_i;
    logic        pc_stall_o;
    logic        if_id_stall_o;
    logic        if_id_flush_o;
    logic        id_ex_bubble_o;
    logic [31:0] stall_count_o;
    logic        sb_error_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [2:0] exp_q[$];

    hazard_scoreboard #(.NUM_REGS(32), .CNT_W(2), .WB_BYPASS(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid_i     (id_valid_i),
        .id_rs1_addr_i  (id_rs1_addr_i),
        .id_rs2_addr_i  (id_rs2_addr_i),
        .id_rs1_used_i  (id_rs1_used_i),
        .id_rs2_used_i  (id_rs2_used_i),
        .id_rd_addr_i   (id_rd_addr_i),
        .id_reg_write_i (id_reg_write_i),
        .wb_valid_i     (wb_valid_i),
        .wb_rd_addr_i   (wb_rd_addr_i),
        .wb_reg_write_i (wb_reg_write_i),
        .ex_redirect_i  (ex_redirect_i),
        .pc_stall_o     (pc_stall_o),
        .if_id_stall_o  (if_id_stall_o),
        .if_id_flush_o  (if_id_flush_o),
        .id_ex_bubble_o (id_ex_bubble_o),
        .stall_count_o  (stall_count_o),
        .sb_error_o     (sb_error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        id_valid_i = 0; id_rs1_addr_i = 0; id_rs2_addr_i = 0; id_rs1_used_i = 0;
        id_rs2_used_i = 0; id_rd_addr_i = 0; id_reg_write_i = 0; wb_valid_i = 0;
        wb_rd_addr_i = 0; wb_reg_write_i = 0; ex_redirect_i = 0;
    endtask

    // One pipeline cycle: drive ID/WB/EX inputs, queue the expected controls, compare.
    task automatic step(input string tag,
                        input logic idv, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic rw,
                        input logic wbv, input logic [4:0] wbrd, input logic wbw,
                        input logic redir,
                        input logic es, input logic eb, input logic ef);
        logic [2:0] e;
        @(negedge clk);
        id_valid_i = idv; id_rs1_addr_i = rs1; id_rs1_used_i = u1;
        id_rs2_addr_i = rs2; id_rs2_used_i = u2; id_rd_addr_i = rd; id_reg_write_i = rw;
        wb_valid_i = wbv; wb_rd_addr_i = wbrd; wb_reg_write_i = wbw; ex_redirect_i = redir;
        exp_q.push_back({es, eb, ef});
        #1;
        e = exp_q.pop_front();
        chk1({tag, ".pc_stall"}, pc_stall_o, e[2]);
        chk1({tag, ".if_id_stall"}, if_id_stall_o, e[2]);
        chk1({tag, ".bubble"}, id_ex_bubble_o, e[1]);
        chk1({tag, ".flush"}, if_id_flush_o, e[0]);
        $display("step %-14s stall=%0b bubble=%0b flush=%0b cnt=%0d err=%0b",
                 tag, pc_stall_o, id_ex_bubble_o, if_id_flush_o, stall_count_o, sb_error_o);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #2;
        chk1("rst.pc_stall", pc_stall_o, 1'b0);
        chk1("rst.bubble", id_ex_bubble_o, 1'b0);
        chk1("rst.flush", if_id_flush_o, 1'b0);
        chk32("rst.stall_count", stall_count_o, 32'd0);
        chk1("rst.sb_error", sb_error_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        //    tag              idv rs1 u1 rs2 u2 rd rw wbv wbrd wbw rdr  es eb ef
        step("idle",            0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0);
        step("addi_x1",         1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 0);
        step("add_x2_s1",       1, 1, 1, 0, 1, 2, 1, 0, 0, 0, 0,   1, 1, 0);
        step("add_x2_s2",       1, 1, 1, 0, 1, 2, 1, 0, 0, 0, 0,   1, 1, 0);
        step("add_x2_s3",       1, 1, 1, 0, 1, 2, 1, 0, 0, 0, 0,   1, 1, 0);
        step("add_x2_issue",    1, 1, 1, 0, 1, 2, 1, 1, 1, 1, 0,   0, 0, 0);
        chk32("stall_count_3", stall_count_o, 32'd3);
        step("x0dst_rd_x1",     1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0);
        step("read_x2_pend",    1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0);
        step("wb_x2",           0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0,   0, 0, 0);
        step("read_x2_free",    1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0);

        step("addi_x3",         1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0,   0, 0, 0);
        step("hz_redirect",     1, 3, 1, 0, 0, 6, 1, 0, 0, 0, 1,   0, 1, 1);
        step("redirect_only",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 1);
        step("read_x6",         1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0);
        step("read_x3_rs2",     1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0);
        step("rs2_unused",      1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0);
        step("wb_x3",           0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0,   0, 0, 0);
        step("read_x3_free",    1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0);

        step("w5_a",            1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0,   0, 0, 0);
        step("w5_b",            1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0,   0, 0, 0);
        step("w5_c",            1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0,   0, 0, 0);
        step("rd5_p3_wb",       1, 5, 1, 0, 0, 0, 0, 1, 5, 1, 0,   1, 1, 0);
        step("rd5_p2_wb",       1, 5, 1, 0, 0, 0, 0, 1, 5, 1, 0,   1, 1, 0);
        step("rd5_p1_wb",       1, 5, 1, 0, 0, 0, 0, 1, 5, 1, 0,   0, 0, 0);

        step("w4_a",            1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0,   0, 0, 0);
        step("w4_and_wb4",      1, 0, 0, 0, 0, 4, 1, 1, 4, 1, 0,   0, 0, 0);
        step("read_x4_pend",    1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0);
        step("read_x4_byp",     1, 4, 1, 0, 0, 0, 0, 1, 4, 1, 0,   0, 0, 0);
        step("wb_x0",           0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0,   0, 0, 0);
        step("idle2",           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0);
        chk1("sb_error_clean", sb_error_o, 1'b0);

        step("wb_x7_spur",      0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 0,   0, 0, 0);
        step("idle3",           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0);
        chk1("sb_error_set", sb_error_o, 1'b1);
        step("idle4",           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0);
        chk1("sb_error_sticky", sb_error_o, 1'b1);

        step("w8",              1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0,   0, 0, 0);
        step("rd8_stall",       1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0);
        chk32("stall_count_8", stall_count_o, 32'd8);
        rst_n = 1'b0;
        #1;
        chk1("midrst.pc_stall", pc_stall_o, 1'b0);
        chk1("midrst.if_id_stall", if_id_stall_o, 1'b0);
        chk1("midrst.bubble", id_ex_bubble_o, 1'b0);
        chk1("midrst.flush", if_id_flush_o, 1'b0);
        chk32("midrst.stall_count", stall_count_o, 32'd0);
        chk1("midrst.sb_error", sb_error_o, 1'b0);
        $display("step %-14s stall=%0b cnt=%0d err=%0b", "mid_reset", pc_stall_o, stall_count_o, sb_error_o);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        step("rd8_after_rst",   1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0);
        step("w9_a",            1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0,   0, 0, 0);
        step("w9_b",            1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0,   0, 0, 0);
        step("w9_c",            1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0,   0, 0, 0);
        step("w9_d_ovf",        1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0,   0, 0, 0);
        chk1("sb_error_before_ovf", sb_error_o, 1'b0);
        step("rd9_sat_wb",      1, 9, 1, 0, 0, 0, 0, 1, 9, 1, 0,   1, 1, 0);
        chk1("sb_error_ovf", sb_error_o, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
